// File: rtl/macguffin_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : macguffin_pkg
//  Description : Shared types and helpers for the block packer: byte width,
//                bytes-per-block helper, packer state encoding and the
//                block completion (zero fill / PKCS#7 fill) function.
//  Revision    : 1.0 - initial release
// ============================================================================
package macguffin_pkg;

    localparam int BYTE_W          = 8;
    // Widest block the fill helper can handle; packer blocks must not exceed it.
    localparam int MAX_BLOCK_W     = 256;
    localparam int MAX_BLOCK_BYTES = MAX_BLOCK_W / BYTE_W;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        PAD     = 1'b1
    } pack_state_t;

    // Number of whole bytes carried by one block of the given width.
    function automatic int bytes_per_block(input int block_w);
        return block_w / BYTE_W;
    endfunction

    // Completes a block. blk holds nbytes collected bytes right-justified
    // (most recent byte in bits [7:0]). The result is left-justified within the
    // low nblk bytes: first byte on top, the nblk-nbytes unused low bytes filled
    // with zero, or with the PKCS#7 value nblk-nbytes when pad_en is set.
    function automatic logic [MAX_BLOCK_W-1:0] fill_block(
        input logic [MAX_BLOCK_W-1:0] blk,
        input int                     nbytes,
        input int                     nblk,
        input logic                   pad_en
    );
        logic [MAX_BLOCK_W-1:0] res;
        int                     nfill;
        logic [BYTE_W-1:0]      fill_val;
        nfill    = nblk - nbytes;
        fill_val = pad_en ? nfill[BYTE_W-1:0] : '0;
        res      = blk << (nfill * BYTE_W);
        for (int b = 0; b < MAX_BLOCK_BYTES; b++) begin
            if (b < nfill) begin
                res[b*BYTE_W +: BYTE_W] = fill_val;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_block_packer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_block_packer
//  Description : Packs an 8-bit AXI4-Stream byte stream into BLOCK_SIZE-bit
//                blocks for the encryption pipeline. A message ends on
//                s_axis_tlast; its final (possibly partial) block is completed
//                and flagged with m_axis_tlast. Sustains one byte per cycle.
//                Build option AXIS_PKCS7_PAD_EN: when defined, final blocks are
//                PKCS#7 padded (with an extra full pad block when the message
//                ends on a block boundary); when undefined, unused low bytes of
//                a partial final block are zero-filled.
//                BLOCK_SIZE must be a multiple of 8, at least 16 and at most
//                MAX_BLOCK_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_block_packer
    import macguffin_pkg::*;
#(
    parameter int BLOCK_SIZE = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_W-1:0]     s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [BLOCK_SIZE-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready
);

    localparam int c_NBYTES = bytes_per_block(BLOCK_SIZE);
    localparam int c_CNT_W  = (c_NBYTES > 1) ? $clog2(c_NBYTES) : 1;
    localparam int c_BUF_W  = BLOCK_SIZE - BYTE_W;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_NBYTES - 1);

`ifdef AXIS_PKCS7_PAD_EN
    localparam logic c_PAD_EN = 1'b1;
    // Extra block sent after a message that ends exactly on a block boundary.
    localparam logic [BLOCK_SIZE-1:0] c_PAD_BLOCK =
        BLOCK_SIZE'(fill_block('0, 0, c_NBYTES, 1'b1));
`else
    localparam logic c_PAD_EN = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    pack_state_t             r_state;
    logic [c_CNT_W-1:0]      r_cnt;
    // Only N-1 bytes ever wait here: the N-th byte closes the block directly.
    logic [c_BUF_W-1:0]      r_pack_buf;
    logic [BLOCK_SIZE-1:0]   r_m_data;
    logic                    r_m_valid;
    logic                    r_m_last;

    logic                    w_out_free;
    logic                    w_s_ready;
    logic                    w_accept;
    logic                    w_block_end;
    logic                    w_close;
    logic [BLOCK_SIZE-1:0]   w_shift_buf;
    logic [BLOCK_SIZE-1:0]   w_closed_block;

    assign w_out_free  = !r_m_valid || m_axis_tready;
    assign w_block_end = (r_cnt == c_CNT_LAST);
    assign w_accept    = s_axis_tvalid && w_s_ready;
    assign w_close     = w_accept && (w_block_end || s_axis_tlast);
    assign w_shift_buf = {r_pack_buf, s_axis_tdata};

    // Any byte that closes a block (last byte of a block or a tlast byte) needs
    // a free output register; otherwise the closed block would have nowhere to go.
    always_comb begin
        w_s_ready = 1'b0;
        if (r_state == COLLECT) begin
            w_s_ready = w_out_free || (!w_block_end && !s_axis_tlast);
        end
    end

    // Complete the block being closed: collected bytes plus the incoming byte.
    always_comb begin
        w_closed_block = BLOCK_SIZE'(fill_block(MAX_BLOCK_W'(w_shift_buf),
                                                int'(r_cnt) + 1,
                                                c_NBYTES, c_PAD_EN));
    end

    // Packer FSM, byte counter, packing buffer and output block register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= COLLECT;
            r_cnt      <= '0;
            r_pack_buf <= '0;
            r_m_data   <= '0;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_close) begin
                    r_cnt      <= '0;
                    r_pack_buf <= '0;
                end else begin
                    r_cnt      <= r_cnt + 1'b1;
                    r_pack_buf <= w_shift_buf[c_BUF_W-1:0];
                end
            end

            if (w_close) begin
                r_m_data  <= w_closed_block;
                r_m_valid <= 1'b1;
`ifdef AXIS_PKCS7_PAD_EN
                // A message ending on a block boundary is not final yet: the
                // pad block that follows carries tlast.
                r_m_last  <= s_axis_tlast && !w_block_end;
                if (s_axis_tlast && w_block_end) begin
                    r_state <= PAD;
                end
`else
                r_m_last  <= s_axis_tlast;
`endif
            end
`ifdef AXIS_PKCS7_PAD_EN
            else if ((r_state == PAD) && w_out_free) begin
                r_m_data  <= c_PAD_BLOCK;
                r_m_valid <= 1'b1;
                r_m_last  <= 1'b1;
                r_state   <= COLLECT;
            end
`endif
            else if (m_axis_tready) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end
        end
    end

    assign s_axis_tready = w_s_ready;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tlast  = r_m_last;

endmodule
`default_nettype wire
